mux_nto1_reg: RTL and testbench

Parametrised, registered successor to the team's 2:1 select gate. It selects one of N channels, each W bits wide, onto a registered output. Two modes are supported: fixed selection from an external select input, and automatic round-robin scanning driven by an internal channel counter. It sits between multi-source datapaths and single-consumer logic such as display drivers or shared registers.

---
 rtl/mux_nto1_reg.sv | 69 ++++++
 tb/tb_mux_nto1_reg.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_nto1_reg.sv
// Registered N:1 channel selector with fixed-select and round-robin scan modes.
// Outputs Y/CH/VALID and the scan counter are the only state.
module mux_nto1_reg #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int SW = 2
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            EN,
    input  logic            MODE,
    input  logic [SW-1:0]   SEL,
    input  logic [N*W-1:0]  D,
    output logic [W-1:0]    Y,
    output logic [SW-1:0]   CH,
    output logic            VALID
);

    localparam logic [SW:0]   N_V  = (SW+1)'(N);
    localparam logic [SW-1:0] LAST = SW'(N - 1);

    logic [SW-1:0] cnt;
    logic [SW-1:0] cnt_nxt;
    logic [SW-1:0] idx;
    logic          legal;
    logic [W-1:0]  sel_data;

    always_comb begin
        idx = MODE ? cnt : SEL;
    end

    // Only reachable out of range via SEL when N is not a power of two
    always_comb begin
        legal = ({1'b0, idx} < N_V);
    end

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < N; k++) begin
            if (idx == SW'(k)) begin
                sel_data = D[k*W +: W];
            end
        end
    end

    // Explicit wrap so CNT never holds a value >= N
    always_comb begin
        cnt_nxt = (cnt == LAST) ? '0 : cnt + 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            Y     <= '0;
            CH    <= '0;
            VALID <= 1'b0;
            cnt   <= '0;
        end else if (EN) begin
            Y     <= sel_data;
            CH    <= idx;
            VALID <= legal;
            if (MODE) begin
                cnt <= cnt_nxt;
            end
        end else begin
            VALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_nto1_reg.sv
// Bench for mux_nto1_reg: N=4 and N=3 instances driven in lockstep
// against a modulo-arithmetic reference model.
module tb_mux_nto1_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        mode;
    logic [1:0]  sel;
    logic [31:0] d4;
    logic [23:0] d3;
    logic [7:0]  y4, y3;
    logic [1:0]  ch4, ch3;
    logic        v4, v3;

    int checks = 0;
    int errors = 0;

    int          m_cnt4, m_cnt3;
    logic [10:0] e4, e3;

    always #5 clk = ~clk;

    mux_nto1_reg #(.N(4), .W(8), .SW(2)) dut4 (
        .CLK(clk), .RST(rst), .EN(en), .MODE(mode),
        .SEL(sel), .D(d4), .Y(y4), .CH(ch4), .VALID(v4)
    );

    mux_nto1_reg #(.N(3), .W(8), .SW(2)) dut3 (
        .CLK(clk), .RST(rst), .EN(en), .MODE(mode),
        .SEL(sel), .D(d3), .Y(y3), .CH(ch3), .VALID(v3)
    );

    task automatic model(input int n, input logic [31:0] dv,
                         inout int cnt, inout logic [10:0] e);
        int         ix;
        logic [7:0] y;
        logic       v;
        if (rst) begin
            e   = '0;
            cnt = 0;
        end else if (!en) begin
            e[0] = 1'b0;
        end else begin
            ix = mode ? cnt : int'(sel);
            if (ix < n) begin
                y = 8'((dv >> (8 * ix)) & 32'hff);
                v = 1'b1;
            end else begin
                y = 8'h00;
                v = 1'b0;
            end
            e = {y, 2'(ix), v};
            if (mode) cnt = (cnt + 1) % n;
        end
    endtask

    task automatic tick();
        model(4, d4, m_cnt4, e4);
        model(3, {8'h00, d3}, m_cnt3, e3);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; en = 1; mode = 1; sel = 2'd3;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({y4, ch4, v4} !== 11'h000) begin
                errors++;
                $display("FAIL reset4 got %h want 000", {y4, ch4, v4});
            end
            checks++;
            if ({y3, ch3, v3} !== 11'h000) begin
                errors++;
                $display("FAIL reset3 got %h want 000", {y3, ch3, v3});
            end
        end
        rst = 0;
        tick();
        checks++;
        if ({y4, ch4, v4} !== {8'h11, 2'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_rel got %h want %h",
                     {y4, ch4, v4}, {8'h11, 2'd0, 1'b1});
        end
    endtask

    task automatic test_fixed();
        logic [1:0] sv [3];
        logic [7:0] yv [3];
        sv = '{2'd2, 2'd0, 2'd3};
        yv = '{8'h33, 8'h11, 8'h44};
        rst = 1; tick(); rst = 0;
        mode = 0; en = 1;
        for (int i = 0; i < 3; i++) begin
            sel = sv[i];
            tick();
            checks++;
            if ({y4, ch4, v4} !== {yv[i], sv[i], 1'b1}) begin
                errors++;
                $display("FAIL fixed4 got %h want %h",
                         {y4, ch4, v4}, {yv[i], sv[i], 1'b1});
            end
            checks++;
            if ({y3, ch3, v3} !== e3) begin
                errors++;
                $display("FAIL fixed3 got %h want %h", {y3, ch3, v3}, e3);
            end
        end
        checks++;
        if ({y3, ch3, v3} !== {8'h00, 2'd3, 1'b0}) begin
            errors++;
            $display("FAIL sel_oob3 got %h want %h",
                     {y3, ch3, v3}, {8'h00, 2'd3, 1'b0});
        end
        mode = 1;
        tick();
        checks++;
        if ({y4, ch4} !== {8'h11, 2'd0}) begin
            errors++;
            $display("FAIL cnt_held got %h want 044", {y4, ch4});
        end
    endtask

    task automatic test_wrap();
        logic [7:0] yv [6];
        logic [1:0] c3 [6];
        yv = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11, 8'h22};
        c3 = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
        rst = 1; tick(); rst = 0;
        mode = 1; en = 1; sel = 2'd3;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if ({y4, ch4, v4} !== {yv[i], 2'(i % 4), 1'b1}) begin
                errors++;
                $display("FAIL wrap4[%0d] got %h want %h", i,
                         {y4, ch4, v4}, {yv[i], 2'(i % 4), 1'b1});
            end
            checks++;
            if (ch3 !== c3[i] || {y3, ch3, v3} !== e3) begin
                errors++;
                $display("FAIL wrap3[%0d] got %h want %h", i,
                         {y3, ch3, v3}, e3);
            end
        end
    endtask

    task automatic test_en_hold();
        rst = 1; tick(); rst = 0;
        mode = 1; en = 1;
        tick(); tick();
        en = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({y4, ch4, v4} !== {8'h22, 2'd1, 1'b0}) begin
                errors++;
                $display("FAIL hold4 got %h want %h",
                         {y4, ch4, v4}, {8'h22, 2'd1, 1'b0});
            end
        end
        en = 1;
        tick();
        checks++;
        if ({y4, ch4, v4} !== {8'h33, 2'd2, 1'b1}) begin
            errors++;
            $display("FAIL resume4 got %h want %h",
                     {y4, ch4, v4}, {8'h33, 2'd2, 1'b1});
        end
    endtask

    task automatic test_mode_switch();
        rst = 1; tick(); rst = 0;
        mode = 1; en = 1;
        tick(); tick(); tick();
        checks++;
        if (ch4 !== 2'd2) begin
            errors++;
            $display("FAIL scan_ch2 got %0d want 2", ch4);
        end
        mode = 0; sel = 2'd0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({y4, ch4, v4} !== {8'h11, 2'd0, 1'b1}) begin
                errors++;
                $display("FAIL sw_fixed got %h want %h",
                         {y4, ch4, v4}, {8'h11, 2'd0, 1'b1});
            end
        end
        mode = 1;
        tick();
        checks++;
        if ({y4, ch4, v4} !== {8'h44, 2'd3, 1'b1}) begin
            errors++;
            $display("FAIL sw_resume got %h want %h",
                     {y4, ch4, v4}, {8'h44, 2'd3, 1'b1});
        end
        tick();
        rst = 1; tick(); rst = 0;
        tick();
        checks++;
        if ({y4, ch4, v4} !== {8'h11, 2'd0, 1'b1}) begin
            errors++;
            $display("FAIL mid_rst got %h want %h",
                     {y4, ch4, v4}, {8'h11, 2'd0, 1'b1});
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst  = ($urandom_range(0, 15) == 0);
            en   = ($urandom_range(0, 3) != 0);
            mode = 1'($urandom);
            sel  = 2'($urandom);
            d4   = $urandom;
            d3   = 24'($urandom);
            tick();
            checks++;
            if ({y4, ch4, v4} !== e4) begin
                errors++;
                $display("FAIL rand4[%0d] got %h want %h", i,
                         {y4, ch4, v4}, e4);
            end
            checks++;
            if ({y3, ch3, v3} !== e3) begin
                errors++;
                $display("FAIL rand3[%0d] got %h want %h", i,
                         {y3, ch3, v3}, e3);
            end
        end
    endtask

    initial begin
        rst = 1; en = 0; mode = 0; sel = 0;
        d4 = 32'h4433_2211;
        d3 = 24'h33_2211;
        m_cnt4 = 0; m_cnt3 = 0;
        e4 = '0; e3 = '0;
        @(negedge clk);
        test_reset();
        test_fixed();
        test_wrap();
        test_en_hold();
        test_mode_switch();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
